// File: rtl/axis_addr_arb_pkg.sv
// ---------------------------------------------------------------------------
// axis_addr_arb_pkg
//   Shared definitions for the AXI write-address arbiter slice:
//   - one-hot FSM state encoding and the bit index of each state
//   - clog2 helper used to size counters at elaboration time
// ---------------------------------------------------------------------------
package axis_addr_arb_pkg;

  localparam int IDLE_IDX  = 0;
  localparam int GRANT_IDX = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    GRANT = 2'b10
  } arb_state_e;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_addr_arb_if.sv
// ---------------------------------------------------------------------------
// axis_addr_arb_if
//   Bundles the three handshake groups around the address arbiter:
//   - req_*  : per-port burst requests from the address generators
//   - axi_*  : the shared AXI write-address channel
//   - ord_*  : head of the grant-order FIFO consumed by the write-data mux
//   Modports:
//   - master : the arbiter side (accepts requests, drives AW and order head)
//   - slave  : the environment side (generators, AXI slave, data mux)
// ---------------------------------------------------------------------------
interface axis_addr_arb_if
  import axis_addr_arb_pkg::*;
#(
  parameter int NB_PORTS       = 2,
  parameter int PORT_WIDTH     = 1,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_ADDR_WIDTH = 32
);

  logic [NB_PORTS*AXI_ADDR_WIDTH-1:0] req_aaddr;
  logic [NB_PORTS*AXI_LEN_WIDTH-1:0]  req_alen;
  logic [NB_PORTS-1:0]                req_avalid;
  logic [NB_PORTS-1:0]                req_aready;

  logic [AXI_ADDR_WIDTH-1:0]          axi_aaddr;
  logic [AXI_LEN_WIDTH-1:0]           axi_alen;
  logic                               axi_avalid;
  logic                               axi_aready;

  logic [PORT_WIDTH-1:0]              ord_port;
  logic [AXI_LEN_WIDTH-1:0]           ord_len;
  logic                               ord_valid;
  logic                               ord_ready;

  modport master (
    input  req_aaddr, req_alen, req_avalid,
    output req_aready,
    output axi_aaddr, axi_alen, axi_avalid,
    input  axi_aready,
    output ord_port, ord_len, ord_valid,
    input  ord_ready
  );

  modport slave (
    output req_aaddr, req_alen, req_avalid,
    input  req_aready,
    input  axi_aaddr, axi_alen, axi_avalid,
    output axi_aready,
    input  ord_port, ord_len, ord_valid,
    output ord_ready
  );

endinterface

// File: rtl/axis_addr_arb_order_fifo.sv
// ---------------------------------------------------------------------------
// axis_order_fifo
//   Synchronous first-word-fall-through FIFO recording the order of granted
//   bursts. pop_data always shows the head entry while empty is low.
//   Ports:
//   - clk, rst          : clock, synchronous active-high reset (empties FIFO)
//   - push, push_data   : write one entry
//   - pop               : drop the head entry (ignored while empty)
//   - pop_data          : head entry
//   - full, empty       : occupancy flags
//   Push and pop in the same cycle keep the occupancy unchanged, and a push
//   is accepted while full as long as a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module axis_order_fifo
  import axis_addr_arb_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int AWIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int CW    = clog2(DEPTH + 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [CW-1:0]     count;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  // When full, the same-cycle pop frees the slot the push is about to use.
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH because they are exactly AWIDTH bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AWIDTH'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AWIDTH'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axis_addr_arb.sv
// ---------------------------------------------------------------------------
// axis_addr_arb
//   Round-robin arbiter sharing one AXI write-address channel among NB_PORTS
//   burst address generators. Each arbitration grants one request, registers
//   its address/length onto the AW channel and records {port, len} in an
//   order FIFO so the write-data mux can forward beats in grant order.
//   Ports:
//   - clk, rst : clock, synchronous active-high reset
//   - bus      : axis_addr_arb_if.master
//       req_aaddr/req_alen/req_avalid in, req_aready out (one-hot pulse)
//       axi_aaddr/axi_alen/axi_avalid out (registered), axi_aready in
//       ord_port/ord_len/ord_valid out (FIFO head), ord_ready in (pop)
// ---------------------------------------------------------------------------
module axis_addr_arb
  import axis_addr_arb_pkg::*;
#(
  parameter int NB_PORTS       = 2,
  parameter int PORT_WIDTH     = 1,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int ORD_AWIDTH     = 3
) (
  input  logic               clk,
  input  logic               rst,
  axis_addr_arb_if.master    bus
);

  localparam int ORD_W = PORT_WIDTH + AXI_LEN_WIDTH;

  arb_state_e                state;
  arb_state_e                state_nxt;
  logic [PORT_WIDTH-1:0]     ptr;
  logic [PORT_WIDTH-1:0]     sel;
  logic                      sel_found;
  logic                      grant;
  logic [2*NB_PORTS-1:0]     req_dbl;
  logic [2*NB_PORTS-1:0]     req_msk;
  logic [AXI_ADDR_WIDTH-1:0] sel_addr;
  logic [AXI_LEN_WIDTH-1:0]  sel_len;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_p1;
  logic [AXI_LEN_WIDTH-1:0]  aw_len_p1;
  logic                      ord_full;
  logic                      ord_empty;
  logic [ORD_W-1:0]          ord_head;

  // Round-robin select: the request vector is doubled so the window
  // ptr+1 .. ptr+NB_PORTS is contiguous; the lowest set bit in that window
  // (modulo NB_PORTS) is the next port in rotation after ptr.
  always_comb begin
    req_dbl   = {bus.req_avalid, bus.req_avalid};
    req_msk   = '0;
    sel       = '0;
    sel_found = 1'b0;
    for (int j = 0; j < 2 * NB_PORTS; j++) begin
      req_msk[j] = req_dbl[j] && (j > int'(ptr)) && (j <= int'(ptr) + NB_PORTS);
    end
    // Descending scan: the last hit written is the lowest index.
    for (int j = 2 * NB_PORTS - 1; j >= 0; j--) begin
      if (req_msk[j]) begin
        sel_found = 1'b1;
        sel       = PORT_WIDTH'(j % NB_PORTS);
      end
    end
  end

  assign sel_addr = bus.req_aaddr[int'(sel)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
  assign sel_len  = bus.req_alen[int'(sel)*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];

  // A full order FIFO only holds off new grants; an issued AW stays valid.
  // Gating with rst keeps req_aready low and the FIFO untouched in reset.
  assign grant = state[IDLE_IDX] && sel_found && !ord_full && !rst;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant)          state_nxt = GRANT;
      GRANT:   if (bus.axi_aready) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= PORT_WIDTH'(NB_PORTS - 1);
    end else begin
      state <= state_nxt;
      if (grant) ptr <= sel;
    end
  end

  always_comb begin
    bus.req_aready = '0;
    if (grant) bus.req_aready[sel] = 1'b1;
  end

  // Stage 1: granted request registered onto the AW channel
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_addr_p1 <= '0;
      aw_len_p1  <= '0;
    end else if (grant) begin
      aw_addr_p1 <= sel_addr;
      aw_len_p1  <= sel_len;
    end
  end

  assign bus.axi_aaddr  = aw_addr_p1;
  assign bus.axi_alen   = aw_len_p1;
  assign bus.axi_avalid = state[GRANT_IDX];

  axis_order_fifo #(
    .WIDTH  (ORD_W),
    .AWIDTH (ORD_AWIDTH)
  ) u_order_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant),
    .push_data ({sel, sel_len}),
    .pop       (bus.ord_ready),
    .pop_data  (ord_head),
    .full      (ord_full),
    .empty     (ord_empty)
  );

  assign bus.ord_port  = ord_head[AXI_LEN_WIDTH +: PORT_WIDTH];
  assign bus.ord_len   = ord_head[AXI_LEN_WIDTH-1:0];
  assign bus.ord_valid = !ord_empty;

endmodule

// File: tb/tb_axis_addr_arb.sv
// ---------------------------------------------------------------------------
// tb_axis_addr_arb
//   Directed bench for axis_addr_arb with two ports, 32-bit addresses,
//   8-bit lengths and an 8-deep order FIFO. Inputs are driven 1 ns after the
//   rising edge; outputs are sampled 1-2 ns after it.
// ---------------------------------------------------------------------------
module tb_axis_addr_arb;

  localparam int NB_PORTS = 2;
  localparam int PW       = 1;
  localparam int LW       = 8;
  localparam int AW       = 32;
  localparam int OAW      = 3;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  axis_addr_arb_if #(
    .NB_PORTS       (NB_PORTS),
    .PORT_WIDTH     (PW),
    .AXI_LEN_WIDTH  (LW),
    .AXI_ADDR_WIDTH (AW)
  ) bus ();

  axis_addr_arb #(
    .NB_PORTS       (NB_PORTS),
    .PORT_WIDTH     (PW),
    .AXI_LEN_WIDTH  (LW),
    .AXI_ADDR_WIDTH (AW),
    .ORD_AWIDTH     (OAW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [7:0] l, input logic v);
    bus.req_aaddr[p*AW +: AW] = a;
    bus.req_alen[p*LW +: LW]  = l;
    bus.req_avalid[p]         = v;
  endtask

  initial begin
    int ng;
    int g0;
    int g1;
    logic [31:0] last_addr;
    logic [1:0]  exp_rdy;
    n_chk  = 0;
    n_pass = 0;

    // ---------------- reset state
    rst            = 1'b1;
    bus.req_aaddr  = '0;
    bus.req_alen   = '0;
    bus.req_avalid = '0;
    bus.axi_aready = 1'b0;
    bus.ord_ready  = 1'b0;
    tick();
    tick();
    chk("rst_avalid", bus.axi_avalid, 0);
    chk("rst_aready", bus.req_aready, 0);
    chk("rst_ord_valid", bus.ord_valid, 0);
    chk("rst_aaddr", bus.axi_aaddr, 0);
    chk("rst_alen", bus.axi_alen, 0);
    rst = 1'b0;

    // ---------------- single port
    set_req(0, 32'h0000_1000, 8'd255, 1'b1);
    #1;
    chk("single_aready", bus.req_aready, 2'b01);
    tick();
    set_req(0, 32'h0000_1000, 8'd255, 1'b0);
    #1;
    chk("single_aready_low", bus.req_aready, 0);
    chk("single_avalid", bus.axi_avalid, 1);
    chk("single_aaddr", bus.axi_aaddr, 32'h1000);
    chk("single_alen", bus.axi_alen, 255);
    chk("single_ord_valid", bus.ord_valid, 1);
    chk("single_ord_port", bus.ord_port, 0);
    chk("single_ord_len", bus.ord_len, 255);
    bus.axi_aready = 1'b1;
    bus.ord_ready  = 1'b1;
    tick();
    chk("single_avalid_drop", bus.axi_avalid, 0);
    chk("single_ord_popped", bus.ord_valid, 0);

    // ---------------- fairness: last grant was port 0, so port 1 leads
    set_req(0, 32'h0000_A000, 8'h01, 1'b1);
    set_req(1, 32'h0000_B000, 8'h02, 1'b1);
    ng = 0; g0 = 0; g1 = 0; last_addr = '0;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (bus.axi_avalid) chk("rr_aaddr", bus.axi_aaddr, last_addr);
      if (bus.req_aready != 0) begin
        exp_rdy = (ng % 2 == 0) ? 2'b10 : 2'b01;
        chk("rr_order", bus.req_aready, exp_rdy);
        if (bus.req_aready[0]) begin g0++; last_addr = 32'h0000_A000; end
        if (bus.req_aready[1]) begin g1++; last_addr = 32'h0000_B000; end
        ng++;
      end
      tick();
    end
    set_req(0, 32'h0000_A000, 8'h01, 1'b0);
    set_req(1, 32'h0000_B000, 8'h02, 1'b0);
    chk("rr_grants", ng, 8);
    chk("rr_port0", g0, 4);
    chk("rr_port1", g1, 4);
    chk("rr_ord_empty", bus.ord_valid, 0);
    bus.axi_aready = 1'b0;
    bus.ord_ready  = 1'b0;

    // ---------------- backpressure
    set_req(1, 32'h0000_2000, 8'd7, 1'b1);
    #1;
    chk("bp_grant", bus.req_aready, 2'b10);
    tick();
    set_req(1, 32'h0000_2000, 8'd7, 1'b0);
    set_req(0, 32'h0000_3000, 8'd3, 1'b1);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("bp_avalid", bus.axi_avalid, 1);
      chk("bp_aaddr", bus.axi_aaddr, 32'h2000);
      chk("bp_alen", bus.axi_alen, 7);
      chk("bp_no_aready", bus.req_aready, 0);
      tick();
    end
    bus.axi_aready = 1'b1;
    tick();
    bus.axi_aready = 1'b0;
    #1;
    chk("bp_release_avalid", bus.axi_avalid, 0);
    chk("bp_next_grant", bus.req_aready, 2'b01);
    tick();
    set_req(0, 32'h0000_3000, 8'd3, 1'b0);
    chk("bp_next_aaddr", bus.axi_aaddr, 32'h3000);
    chk("bp_next_alen", bus.axi_alen, 3);
    chk("bp_next_avalid", bus.axi_avalid, 1);
    chk("bp_ord_port0", bus.ord_port, 1);
    chk("bp_ord_len0", bus.ord_len, 7);
    bus.ord_ready = 1'b1;
    tick();
    chk("bp_ord_port1", bus.ord_port, 0);
    chk("bp_ord_len1", bus.ord_len, 3);
    tick();
    chk("bp_ord_empty", bus.ord_valid, 0);
    bus.ord_ready  = 1'b0;
    bus.axi_aready = 1'b1;
    tick();
    bus.axi_aready = 1'b0;

    // ---------------- FIFO full (last grant port 0 -> port 1 leads)
    set_req(0, 32'h0000_4000, 8'h10, 1'b1);
    set_req(1, 32'h0000_4100, 8'h11, 1'b1);
    bus.axi_aready = 1'b1;
    ng = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (bus.req_aready != 0) ng++;
      tick();
    end
    chk("full_grants", ng, 8);
    #1;
    chk("full_avalid", bus.axi_avalid, 0);
    chk("full_stall", bus.req_aready, 0);
    chk("full_ord_valid", bus.ord_valid, 1);
    chk("full_head", bus.ord_port, 1);
    bus.ord_ready = 1'b1;
    #1;
    chk("full_pop_nogrant", bus.req_aready, 0);
    tick();
    #1;
    chk("full_ninth_grant", bus.req_aready, 2'b10);
    tick();
    bus.ord_ready = 1'b0;
    chk("full_pushpop_head", bus.ord_port, 1);
    tick();
    #1;
    chk("full_tenth_grant", bus.req_aready, 2'b01);
    tick();
    tick();
    #1;
    chk("full_refull_stall", bus.req_aready, 0);
    chk("full_refull_avalid", bus.axi_avalid, 0);
    set_req(0, 32'h0000_4000, 8'h10, 1'b0);
    set_req(1, 32'h0000_4100, 8'h11, 1'b0);
    bus.axi_aready = 1'b0;
    bus.ord_ready  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", bus.ord_valid, 1);
      chk("drain_port", bus.ord_port, (k % 2 == 0) ? 1 : 0);
      chk("drain_len", bus.ord_len, (k % 2 == 0) ? 8'h11 : 8'h10);
      tick();
    end
    chk("drain_empty", bus.ord_valid, 0);

    // ---------------- pop while empty
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("empty_pop_valid", bus.ord_valid, 0);
      tick();
    end
    bus.ord_ready = 1'b0;
    set_req(1, 32'h0000_5000, 8'h22, 1'b1);
    #1;
    chk("empty_then_grant", bus.req_aready, 2'b10);
    tick();
    set_req(1, 32'h0000_5000, 8'h22, 1'b0);
    chk("empty_then_avalid", bus.axi_avalid, 1);
    chk("empty_then_aaddr", bus.axi_aaddr, 32'h5000);
    chk("empty_then_ord_valid", bus.ord_valid, 1);
    chk("empty_then_ord_port", bus.ord_port, 1);
    chk("empty_then_ord_len", bus.ord_len, 8'h22);

    // ---------------- reset mid-GRANT with three FIFO entries
    bus.axi_aready = 1'b1;
    set_req(0, 32'h0000_6000, 8'h30, 1'b1);
    tick();
    #1;
    chk("pre_rst_grant0", bus.req_aready, 2'b01);
    tick();
    set_req(0, 32'h0000_6000, 8'h30, 1'b0);
    set_req(1, 32'h0000_6100, 8'h31, 1'b1);
    tick();
    #1;
    chk("pre_rst_grant1", bus.req_aready, 2'b10);
    tick();
    set_req(1, 32'h0000_6100, 8'h31, 1'b0);
    bus.axi_aready = 1'b0;
    chk("pre_rst_avalid", bus.axi_avalid, 1);
    chk("pre_rst_ord_head", bus.ord_len, 8'h22);
    rst = 1'b1;
    set_req(1, 32'h0000_7000, 8'h40, 1'b1);
    #1;
    chk("rst_gates_aready", bus.req_aready, 0);
    tick();
    rst = 1'b0;
    chk("post_rst_avalid", bus.axi_avalid, 0);
    chk("post_rst_ord_valid", bus.ord_valid, 0);
    set_req(0, 32'h0000_8000, 8'h50, 1'b1);
    #1;
    chk("post_rst_first_port0", bus.req_aready, 2'b01);
    tick();
    set_req(0, 32'h0000_8000, 8'h50, 1'b0);
    set_req(1, 32'h0000_7000, 8'h40, 1'b0);
    chk("post_rst_aaddr", bus.axi_aaddr, 32'h8000);
    chk("post_rst_avalid_hi", bus.axi_avalid, 1);
    chk("post_rst_ord_port", bus.ord_port, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
